// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   RESET_PC      : byte address fetched and decoded after reset
//   inst_window_t : 24-bit little-endian instruction window seen by the decoder
//   byte_count_t  : 0-3 byte count (window valid bytes, decoder consume)
package cpu_pkg;

    localparam logic [15:0] RESET_PC = 16'h4000;

    typedef logic [23:0] inst_window_t;
    typedef logic [1:0]  byte_count_t;

endpackage

// File: rtl/inst_byte_queue.sv
// Circular byte FIFO feeding the decode window.
//   clk, reset   : clock, synchronous active-high reset
//   flush_i      : drop all queued bytes (wins over push/pop)
//   push_i       : enqueue two bytes, push_data_i[7:0] first, then push_data_i[15:8]
//   pop_i        : dequeue 0-3 bytes (caller guarantees pop_i <= count_o)
//   count_o      : bytes currently held
//   window_o     : up to three head bytes, oldest in [7:0]; bytes beyond count_o read as 0
module inst_byte_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [15:0] push_data_i,
    input  logic [1:0]  pop_i,
    output logic [3:0]  count_o,
    output logic [23:0] window_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]      count_q, count_d;

    // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PtrW'(s);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = ptr_add(rd_ptr_q, 32'(pop_i));
            if (push_i) wr_ptr_d = ptr_add(wr_ptr_q, 32'd2);
            count_d = count_q - {2'b00, pop_i} + (push_i ? 4'd2 : 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: every read is masked by count_q.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !reset) begin
            mem_q[wr_ptr_q]             <= push_data_i[7:0];
            mem_q[ptr_add(wr_ptr_q, 1)] <= push_data_i[15:8];
        end
    end

    always_comb begin
        window_o = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (count_q > 4'(i)) window_o[8*i +: 8] = mem_q[ptr_add(rd_ptr_q, i)];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch stage in front of the decoder.
// Fetches two bytes per cycle from an even/odd byte-bank memory, queues them and presents a
// three-byte little-endian window to the decoder.
//   clk, reset                 : clock, synchronous active-high reset
//   mem_read_en                : read issued this cycle
//   mem_read_addr_even/_odd    : bank word addresses (always driven from fetch_addr)
//   mem_read_data_even/_odd    : bank data, one cycle after the address
//   redirect, redirect_pc      : flush and restart fetch/decode at redirect_pc
//   consume                    : bytes retired by the decoder (0-3)
//   inst_window, valid_bytes   : decode window and number of valid bytes in it
//   decode_pc                  : byte address of inst_window[7:0]
// Optional macro PREFETCH_PERF_EN adds saturating counters starve_cycles and redirect_count.
module inst_prefetch
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 6,
    parameter logic [15:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_read_en,
    output logic [14:0] mem_read_addr_even,
    input  logic [7:0]  mem_read_data_even,
    output logic [14:0] mem_read_addr_odd,
    input  logic [7:0]  mem_read_data_odd,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [1:0]  consume,
    output logic [23:0] inst_window,
    output logic [1:0]  valid_bytes,
    output logic [15:0] decode_pc
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0] starve_cycles,
    output logic [15:0] redirect_count
`endif
);

    logic [15:0]  fetch_addr_q, fetch_addr_d;
    logic [15:0]  decode_pc_q, decode_pc_d;
    logic         inflight_q, inflight_d;
    logic         odd_first_q, odd_first_d;
    logic [3:0]   count;
    inst_window_t window;
    byte_count_t  vb;
    byte_count_t  pop;
    logic         push;
    logic [15:0]  push_data;

    // An odd start address needs the even byte from the next word.
    assign mem_read_addr_odd  = fetch_addr_q[15:1];
    assign mem_read_addr_even = fetch_addr_q[15:1] + 15'(fetch_addr_q[0]);

    // Reserve room for the response still in flight so the queue can never overflow.
    assign mem_read_en = !reset && !redirect &&
                         (({1'b0, count} + {3'b000, inflight_q, 1'b0}) <= 5'(DEPTH - 2));

    assign vb   = (count >= 4'd3) ? 2'd3 : count[1:0];
    assign pop  = (consume > vb) ? vb : consume;
    assign push = inflight_q && !redirect;
    // Lower byte enters the queue first: it is the one at the issued (lower) address.
    assign push_data = odd_first_q ? {mem_read_data_even, mem_read_data_odd}
                                   : {mem_read_data_odd, mem_read_data_even};

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        decode_pc_d  = decode_pc_q + 16'(pop);
        inflight_d   = mem_read_en;
        odd_first_d  = odd_first_q;
        if (mem_read_en) begin
            fetch_addr_d = fetch_addr_q + 16'd2;
            odd_first_d  = fetch_addr_q[0];
        end
        if (redirect) begin
            fetch_addr_d = redirect_pc;
            decode_pc_d  = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr_q <= RESET_PC;
            decode_pc_q  <= RESET_PC;
            inflight_q   <= 1'b0;
            odd_first_q  <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            decode_pc_q  <= decode_pc_d;
            inflight_q   <= inflight_d;
            odd_first_q  <= odd_first_d;
        end
    end

    inst_byte_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .count_o     (count),
        .window_o    (window)
    );

    assign inst_window = window;
    assign valid_bytes = vb;
    assign decode_pc   = decode_pc_q;

    // Over-consumption is clamped in hardware; flag it in simulation.
    consume_within_window: assert property (@(posedge clk) disable iff (reset)
        redirect || (consume <= valid_bytes));

`ifdef PREFETCH_PERF_EN
    logic [15:0] starve_q;
    logic [15:0] redir_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (vb == 2'd0 && starve_q != 16'hFFFF) starve_q <= starve_q + 16'd1;
            if (redirect && redir_cnt_q != 16'hFFFF) redir_cnt_q <= redir_cnt_q + 16'd1;
        end
    end

    assign starve_cycles  = starve_q;
    assign redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
module tb_inst_prefetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read_en;
    logic [14:0] mem_read_addr_even, mem_read_addr_odd;
    logic [7:0]  mem_read_data_even = 8'h00, mem_read_data_odd = 8'h00;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [1:0]  consume = 2'd0;
    logic [23:0] inst_window;
    logic [1:0]  valid_bytes;
    logic [15:0] decode_pc;
`ifdef PREFETCH_PERF_EN
    logic [15:0] starve_cycles, redirect_count;
`endif

    inst_prefetch dut (
        .clk                (clk),
        .reset              (reset),
        .mem_read_en        (mem_read_en),
        .mem_read_addr_even (mem_read_addr_even),
        .mem_read_data_even (mem_read_data_even),
        .mem_read_addr_odd  (mem_read_addr_odd),
        .mem_read_data_odd  (mem_read_data_odd),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .consume            (consume),
        .inst_window        (inst_window),
        .valid_bytes        (valid_bytes),
        .decode_pc          (decode_pc)
`ifdef PREFETCH_PERF_EN
        ,
        .starve_cycles      (starve_cycles),
        .redirect_count     (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    // Byte-addressed memory; bank k of word w holds byte 2*w+k.
    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        mem_read_data_even <= mem[{mem_read_addr_even, 1'b0}];
        mem_read_data_odd  <= mem[{mem_read_addr_odd, 1'b1}];
    end

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endfunction

    // Expected window: the n bytes of the program stream starting at pc, zero-filled.
    function automatic logic [23:0] exp_win(input logic [15:0] pc, input int n);
        logic [23:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = mem[16'(pc + 16'(i))];
        return w;
    endfunction

    typedef struct {
        logic [15:0] pc;
        logic [23:0] win;
    } rec_t;

    rec_t        sb_q[$];
    rec_t        mon_rec;
    bit          sb_en = 1'b0;
    logic [15:0] exp_pc;

    // Monitor: whenever the decoder is shown bytes, they must be the next bytes of the stream.
    always @(negedge clk) begin
        #1;
        if (sb_en && !reset && !redirect && valid_bytes != 2'd0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: window %0h shown with no expected entry", inst_window);
            end else begin
                mon_rec = sb_q.pop_front();
                check("sb_decode_pc", 32'(decode_pc), 32'(mon_rec.pc));
                check("sb_window", 32'(inst_window), 32'(mon_rec.win));
            end
        end
    end

    // One scoreboard cycle. mode 0: random consume with occasional redirect; 1: greedy consume.
    task automatic sb_cycle(input int mode);
        logic [1:0] vb;
        int         n;
        @(negedge clk);
        vb = valid_bytes;
        redirect = 1'b0;
        consume  = 2'd0;
        if (mode == 0 && $urandom_range(0, 19) == 0) begin
            redirect    = 1'b1;
            redirect_pc = 16'($urandom);
            consume     = 2'($urandom_range(0, int'(vb)));
            exp_pc      = redirect_pc;
        end else begin
            n = (mode == 1) ? int'(vb) : $urandom_range(0, int'(vb));
            consume = 2'(n);
            if (vb != 2'd0) sb_q.push_back('{pc: exp_pc, win: exp_win(exp_pc, int'(vb))});
            exp_pc = 16'(exp_pc + 16'(n));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        redirect = 1'b0;
        consume  = 2'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_valid_bytes", 32'(valid_bytes), 32'd0);
        check("rst_window", 32'(inst_window), 32'd0);
        check("rst_decode_pc", 32'(decode_pc), 32'h4000);
        check("rst_read_en", 32'(mem_read_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [15:0] start_pc;
`ifdef PREFETCH_PERF_EN
    logic [15:0] rc0;
`endif

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'h4000] = 8'hAA;
        mem[16'h4001] = 8'hBB;

        // Reset and first fetches; cycle 0 is the first cycle with reset low.
        do_reset();
        #1;
        check("c0_read_en", 32'(mem_read_en), 32'd1);
        check("c0_addr_even", 32'(mem_read_addr_even), 32'h2000);
        check("c0_addr_odd", 32'(mem_read_addr_odd), 32'h2000);
        @(negedge clk); #1;
        check("c1_read_en", 32'(mem_read_en), 32'd1);
        check("c1_addr_even", 32'(mem_read_addr_even), 32'h2001);
        check("c1_addr_odd", 32'(mem_read_addr_odd), 32'h2001);
        @(negedge clk); #1;
        check("c2_valid_bytes", 32'(valid_bytes), 32'd2);
        check("c2_window", 32'(inst_window), 32'h00BBAA);
        check("c2_decode_pc", 32'(decode_pc), 32'h4000);

        // Hold consume=0 until the queue fills.
        repeat (4) @(negedge clk);
        #1;
        check("full_valid_bytes", 32'(valid_bytes), 32'd3);
        check("full_read_en", 32'(mem_read_en), 32'd0);
        check("full_window", 32'(inst_window), 32'(exp_win(16'h4000, 3)));
        consume = 2'd3;
        @(negedge clk);
        consume = 2'd0;
        #1;
        check("full_pop_pc", 32'(decode_pc), 32'h4003);
        check("full_pop_valid", 32'(valid_bytes), 32'd3);
        check("full_pop_window", 32'(inst_window), 32'(exp_win(16'h4003, 3)));

        // Redirect to an odd address while the first response is in flight.
        do_reset();
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 16'h5001;
        #1;
        check("redir_no_issue", 32'(mem_read_en), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("redir_decode_pc", 32'(decode_pc), 32'h5001);
        check("redir_empty", 32'(valid_bytes), 32'd0);
        check("redir_read_en", 32'(mem_read_en), 32'd1);
        check("redir_addr_odd", 32'(mem_read_addr_odd), 32'h2800);
        check("redir_addr_even", 32'(mem_read_addr_even), 32'h2801);
        @(negedge clk); #1;
        check("redir_still_empty", 32'(valid_bytes), 32'd0);
        @(negedge clk); #1;
        check("redir_valid", 32'(valid_bytes), 32'd2);
        check("redir_window", 32'(inst_window), 32'(exp_win(16'h5001, 2)));

        // Redirect to the top of the address space.
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("wrap_addr_odd", 32'(mem_read_addr_odd), 32'h7FFF);
        check("wrap_addr_even", 32'(mem_read_addr_even), 32'h0000);
        @(negedge clk);
        @(negedge clk); #1;
        check("wrap_valid", 32'(valid_bytes), 32'd2);
        check("wrap_window", 32'(inst_window), 32'(exp_win(16'hFFFF, 2)));
        check("wrap_hi_zero", 32'(inst_window[23:16]), 32'd0);
        consume = 2'd1;
        @(negedge clk);
        consume = 2'd0;
        #1;
        check("wrap_decode_pc", 32'(decode_pc), 32'h0000);

        // Greedy decoder: 2 bytes/cycle once primed, first bytes two cycles after redirect.
        start_pc = 16'($urandom);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = start_pc;
        consume     = 2'd0;
        exp_pc      = start_pc;
        sb_en       = 1'b1;
        for (int k = 0; k < 200; k++) sb_cycle(1);
        @(negedge clk);
        sb_en = 1'b0;
        #1;
        check("rate_decode_pc", 32'(decode_pc), 32'(16'(start_pc + 16'd396)));

        // Redirect beats consume in the same cycle.
`ifdef PREFETCH_PERF_EN
        rc0 = redirect_count;
`endif
        consume     = (valid_bytes >= 2'd2) ? 2'd2 : valid_bytes;
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        @(negedge clk);
        redirect = 1'b0;
        consume  = 2'd0;
        #1;
        check("redir_beats_consume", 32'(decode_pc), 32'h1234);
`ifdef PREFETCH_PERF_EN
        check("redirect_count", 32'(redirect_count), 32'(16'(rc0 + 16'd1)));
`endif

        // Random consume and redirects against the stream model.
        exp_pc = 16'h1234;
        sb_en  = 1'b1;
        for (int k = 0; k < 600; k++) sb_cycle(0);
        @(negedge clk);
        sb_en    = 1'b0;
        redirect = 1'b0;
        consume  = 2'd0;
        #2;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
